dsd_seq: RTL
============

DSD_SEQ -- requirements
Module: dsd_seq

Interface
REQ-001 SHALL have parameter AUDIO_WIDTH, default 24: sample width in bits.
REQ-002 SHALL have parameter COEFF_W, default 16: coefficient width in bits.
REQ-003 SHALL have parameter NCOEFFS, default 32: number of FIR taps, at least 2.
REQ-004 SHALL have parameter DECIM, default 4: decimation ratio, at least 1.
REQ-005 SHALL have parameter MAC_LAT, default 2: downstream MAC pipeline depth in cycles, at least 1.
REQ-006 SHALL define localparam LGN = $clog2(NCOEFFS); data and coefficient memories are 2^LGN deep.
REQ-007 SHALL have ports:
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_valid  in  1  input sample offered.
- i_sample  in  AUDIO_WIDTH  input sample.
- o_ready  out  1  sample accepted when high together with i_valid.
- o_dwr_en, o_dwr_addr, o_dwr_data  out  1/LGN/AUDIO_WIDTH  data-memory write port.
- o_rd_addr_d, o_rd_addr_c  out  LGN  data and coefficient read addresses.
- o_mac_en, o_mac_first, o_mac_last  out  1 each  MAC enable, clear-and-load, final tap.
- o_out_strobe  out  1  one-cycle pulse: decimated output valid at the MAC.

Function
REQ-008 SHALL implement a four-state FSM: IDLE, WR, RUN, DRAIN; o_ready = (state==IDLE), subject to REQ-017.
REQ-009 SHALL, in IDLE on i_valid&&o_ready at cycle t, enter WR at t+1 with o_dwr_en=1, o_dwr_addr=wptr, o_dwr_data=sample registered at t.
REQ-010 SHALL, in WR, post-increment wptr mod 2^LGN and increment phase mod DECIM; if phase was DECIM-1, go to RUN at t+2, otherwise go to IDLE.
REQ-011 SHALL, in RUN, spend exactly NCOEFFS cycles with tap k=0..NCOEFFS-1, o_mac_en=1, o_rd_addr_c=k, and o_rd_addr_d=(newest written address - k) mod 2^LGN.
REQ-012 SHALL assert o_mac_first only at k=0 and o_mac_last only at k=NCOEFFS-1.
REQ-013 SHALL, in DRAIN, hold o_mac_en=0 for MAC_LAT cycles, pulse o_out_strobe in the last DRAIN cycle, then return to IDLE.
REQ-014 SHALL achieve this latency: accept at t gives strobe at t+1+NCOEFFS+MAC_LAT and o_ready=1 at t+2+NCOEFFS+MAC_LAT.
REQ-015 SHALL ignore i_valid while o_ready=0, with no state change and no sample loss; the source holds the sample.
REQ-016 SHALL drive o_dwr_en, o_mac_en, o_mac_first, o_mac_last and o_out_strobe to 0 outside their defined states; address outputs hold their last value.

Reset
REQ-017 SHALL, on i_rst_n=0 at a clock edge, set state=IDLE, wptr=0, phase=0, and all 1-bit outputs and address outputs to 0, with o_ready=1 from the first cycle after reset release.
REQ-018 SHALL, on reset asserted mid-RUN or mid-DRAIN, abort the computation with no o_out_strobe issued for that phase.

Configuration
REQ-019 SHALL provide macro DSD_SEQ_COEF_LOAD_EN; when defined, add ports i_cwr_en (1), i_cwr_addr (LGN), i_cwr_data (COEFF_W), o_cwr_ready (1), o_cwr_en (1), o_cwr_addr (LGN), o_cwr_data (COEFF_W).
REQ-020 SHALL, with the macro defined, set o_cwr_ready=(state==IDLE) and register an accepted write to o_cwr_* one cycle later; o_cwr_en resets to 0.
REQ-021 SHALL, with the macro defined, give a coefficient write priority over a sample when both are offered in IDLE: o_ready=0 that cycle.
REQ-022 SHALL, without the macro, omit those ports; coefficients are static (preloaded memory) and o_ready follows REQ-008 only.

Verification (NCOEFFS=4, DECIM=2, MAC_LAT=2)
REQ-023 SHALL cover: reset, then samples 0x000001 and 0x000002 accepted at t=0 and t=2 -> writes to addr 0 and 1; RUN at t=4..7 with rd_addr_d 1,0,3,2 and rd_addr_c 0..3; strobe at t=9; o_ready at t=10.
REQ-024 SHALL cover: i_valid held high continuously -> exactly one accept per IDLE cycle, one strobe per 2 accepts, no duplicated or dropped write addresses.
REQ-025 SHALL cover: 5 accepted samples with 2^LGN=4 -> write addresses 0,1,2,3,0; the RUN after the 4th sample reads addresses 3,2,1,0.
REQ-026 SHALL cover: i_rst_n pulsed low at RUN k=2 -> no strobe; the next sample is written to addr 0 and phase restarts at 0.
REQ-027 SHALL cover, with DSD_SEQ_COEF_LOAD_EN defined: i_cwr_en and i_valid both high in IDLE with addr 2, data 0x7FFF -> o_cwr_en=1, addr 2, data 0x7FFF one cycle later; sample not accepted; i_cwr_en during RUN is not accepted.

Source files
------------

// File: rtl/dsd_seq.sv
// Decimating FIR sequencer: stores accepted samples, and every DECIM samples sweeps NCOEFFS taps
// into a downstream MAC and then waits out its latency. Optional coefficient load port: DSD_SEQ_COEF_LOAD_EN.
module dsd_seq #(
   parameter int AUDIO_WIDTH = 24,
   parameter int COEFF_W     = 16,
   parameter int NCOEFFS     = 32,
   parameter int DECIM       = 4,
   parameter int MAC_LAT     = 2,
   localparam int LGN        = $clog2(NCOEFFS)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   input  logic [AUDIO_WIDTH-1:0] i_sample,
   output logic                   o_ready,
   output logic                   o_dwr_en,
   output logic [LGN-1:0]         o_dwr_addr,
   output logic [AUDIO_WIDTH-1:0] o_dwr_data,
   output logic [LGN-1:0]         o_rd_addr_d,
   output logic [LGN-1:0]         o_rd_addr_c,
   output logic                   o_mac_en,
   output logic                   o_mac_first,
   output logic                   o_mac_last,
   output logic                   o_out_strobe
`ifdef DSD_SEQ_COEF_LOAD_EN
   ,
   input  logic                   i_cwr_en,
   input  logic [LGN-1:0]         i_cwr_addr,
   input  logic [COEFF_W-1:0]     i_cwr_data,
   output logic                   o_cwr_ready,
   output logic                   o_cwr_en,
   output logic [LGN-1:0]         o_cwr_addr,
   output logic [COEFF_W-1:0]     o_cwr_data
`endif
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [LGN-1:0] LAST_TAP   = LGN'(NCOEFFS - 1);
   localparam logic [PW-1:0]  LAST_PHASE = PW'(DECIM - 1);
   localparam logic [DW-1:0]  LAST_DRAIN = DW'(MAC_LAT - 1);

   if (NCOEFFS < 2 || DECIM < 1 || MAC_LAT < 1 || COEFF_W < 1 || AUDIO_WIDTH < 1) begin : g_bad_params
      $error("dsd_seq: illegal parameter set");
   end

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RUN, S_DRAIN} state_t;

   state_t                 r_state;
   logic [LGN-1:0]         r_wptr;
   logic [PW-1:0]          r_phase;
   logic [LGN-1:0]         r_tap;
   logic [DW-1:0]          r_dcnt;
   logic                   r_dwr_en;
   logic [LGN-1:0]         r_dwr_addr;
   logic [AUDIO_WIDTH-1:0] r_dwr_data;
   logic [LGN-1:0]         r_rd_addr_d;
   logic [LGN-1:0]         r_rd_addr_c;
   logic                   r_mac_en;
   logic                   r_mac_first;
   logic                   r_mac_last;
   logic                   r_out_strobe;

   logic                   w_idle;
   logic                   w_accept;
   logic [LGN-1:0]         w_next_tap;
   logic [DW-1:0]          w_next_dcnt;

   // Sample handshake: a sample transfers on a rising edge where i_valid and o_ready are both high;
   // while o_ready is low the source must hold i_valid/i_sample and nothing is captured.
   assign w_idle      = (r_state == S_IDLE) && i_rst_n;
   assign w_next_tap  = r_tap + 1'b1;
   assign w_next_dcnt = r_dcnt + 1'b1;

`ifdef DSD_SEQ_COEF_LOAD_EN
   logic                   w_cwr_accept;
   logic                   r_cwr_en;
   logic [LGN-1:0]         r_cwr_addr;
   logic [COEFF_W-1:0]     r_cwr_data;

   // A coefficient write wins over a sample offered in the same idle cycle.
   assign o_cwr_ready  = w_idle;
   assign w_cwr_accept = i_cwr_en && o_cwr_ready;
   assign o_ready      = w_idle && !i_cwr_en;
   assign o_cwr_en     = r_cwr_en;
   assign o_cwr_addr   = r_cwr_addr;
   assign o_cwr_data   = r_cwr_data;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cwr_en   <= 1'b0;
         r_cwr_addr <= '0;
         r_cwr_data <= '0;
      end else begin
         r_cwr_en <= w_cwr_accept;
         if (w_cwr_accept) begin
            r_cwr_addr <= i_cwr_addr;
            r_cwr_data <= i_cwr_data;
         end
      end
   end
`else
   assign o_ready = w_idle;
`endif

   assign w_accept = i_valid && o_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_wptr       <= '0;
         r_phase      <= '0;
         r_tap        <= '0;
         r_dcnt       <= '0;
         r_dwr_en     <= 1'b0;
         r_dwr_addr   <= '0;
         r_dwr_data   <= '0;
         r_rd_addr_d  <= '0;
         r_rd_addr_c  <= '0;
         r_mac_en     <= 1'b0;
         r_mac_first  <= 1'b0;
         r_mac_last   <= 1'b0;
         r_out_strobe <= 1'b0;
      end else begin
         r_dwr_en     <= 1'b0;
         r_mac_en     <= 1'b0;
         r_mac_first  <= 1'b0;
         r_mac_last   <= 1'b0;
         r_out_strobe <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dwr_en   <= 1'b1;
                  r_dwr_addr <= r_wptr;
                  r_dwr_data <= i_sample;
                  r_state    <= S_WR;
               end
            end
            S_WR: begin
               r_wptr <= r_wptr + 1'b1;
               if (r_phase == LAST_PHASE) begin
                  // r_wptr still names the sample just written, i.e. the newest one.
                  r_phase     <= '0;
                  r_tap       <= '0;
                  r_mac_en    <= 1'b1;
                  r_mac_first <= 1'b1;
                  r_rd_addr_c <= '0;
                  r_rd_addr_d <= r_wptr;
                  r_state     <= S_RUN;
               end else begin
                  r_phase <= r_phase + 1'b1;
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               if (r_tap == LAST_TAP) begin
                  r_dcnt       <= '0;
                  r_out_strobe <= (MAC_LAT == 1);
                  r_state      <= S_DRAIN;
               end else begin
                  r_tap       <= w_next_tap;
                  r_mac_en    <= 1'b1;
                  r_mac_last  <= (w_next_tap == LAST_TAP);
                  r_rd_addr_c <= w_next_tap;
                  r_rd_addr_d <= r_rd_addr_d - 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_dcnt == LAST_DRAIN) begin
                  r_state <= S_IDLE;
               end else begin
                  r_dcnt       <= w_next_dcnt;
                  r_out_strobe <= (w_next_dcnt == LAST_DRAIN);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_dwr_en     = r_dwr_en;
   assign o_dwr_addr   = r_dwr_addr;
   assign o_dwr_data   = r_dwr_data;
   assign o_rd_addr_d  = r_rd_addr_d;
   assign o_rd_addr_c  = r_rd_addr_c;
   assign o_mac_en     = r_mac_en;
   assign o_mac_first  = r_mac_first;
   assign o_mac_last   = r_mac_last;
   assign o_out_strobe = r_out_strobe;

endmodule
